// File: rtl/ifu_pkg.sv
// Shared constants for the IF stage of the 8-bit pipelined core.
// Halt detection in instr_fetch_unit is enabled by defining IFU_HALT_DETECT_EN.
package ifu_pkg;

    localparam int unsigned ADDR_W    = 8;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned MEM_DEPTH = 256;

    localparam logic [DATA_W-1:0] HALT_OPCODE = 8'hFF;
    localparam logic [DATA_W-1:0] NOP_INSTR   = 8'h00;

endpackage

// File: rtl/instr_mem.sv
// 256x8 instruction store: asynchronous fetch read port, synchronous program write port.
// Contents are deliberately not reset; no dependence on IFU_HALT_DETECT_EN.
module instr_mem
    import ifu_pkg::*;
#(
    parameter int unsigned AW = ADDR_W,
    parameter int unsigned DW = DATA_W
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [2**AW];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // A write to the address being fetched shows up on the following cycle.
    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/instr_fetch_unit.sv
// IF stage: PC register, instruction memory, branch redirect and IF/ID flush generation.
// Define IFU_HALT_DETECT_EN to freeze fetch on an unsquashed HALT opcode.
module instr_fetch_unit #(
    parameter int unsigned       ADDR_W       = 8,
    parameter int unsigned       FLUSH_CYCLES = 1,
    parameter logic [ADDR_W-1:0] RESET_PC     = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              Stall,
    input  logic              Branch_Taken,
    input  logic [ADDR_W-1:0] Branch_Target,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [7:0]        prog_data,
    output logic [7:0]        Instr,
    output logic [ADDR_W-1:0] NPC,
    output logic [ADDR_W-1:0] PC,
    output logic              Flush,
    output logic              Halted
);

    import ifu_pkg::*;

    localparam int unsigned CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;
    logic              halt_hold;

    instr_mem #(
        .AW (ADDR_W),
        .DW (DATA_W)
    ) u_instr_mem (
        .clk     (clk),
        .we_i    (prog_we),
        .waddr_i (prog_addr),
        .wdata_i (prog_data),
        .raddr_i (pc_q),
        .rdata_o (Instr)
    );

    assign PC  = pc_q;
    assign NPC = pc_q + ADDR_W'(1);

    // Gated by reset so an in-flight branch request cannot flush IF/ID during reset.
    assign Flush = ~reset & (Branch_Taken | (flush_cnt_q != '0));

`ifdef IFU_HALT_DETECT_EN
    logic halt_q, halt_d;
    logic halt_det;

    // A HALT fetched under Flush is being squashed and must not stop fetch.
    assign halt_det  = (Instr == HALT_OPCODE) && !Flush;
    assign halt_hold = halt_q | halt_det;
    assign Halted    = halt_q;

    always_comb begin
        halt_d = halt_q | halt_det;
        if (Branch_Taken) begin
            halt_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`else
    assign halt_hold = 1'b0;
    assign Halted    = 1'b0;
`endif

    always_comb begin
        pc_d = NPC;
        if (Branch_Taken) begin
            pc_d = Branch_Target;
        end else if (halt_hold || Stall) begin
            pc_d = pc_q;
        end
    end

    always_comb begin
        flush_cnt_d = flush_cnt_q;
        if (Branch_Taken) begin
            flush_cnt_d = CNT_LOAD;
        end else if (flush_cnt_q != '0) begin
            flush_cnt_d = flush_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            flush_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: two instances (FLUSH_CYCLES 1 and 2) on shared stimulus.
// Halt checks are compiled in when IFU_HALT_DETECT_EN is defined.
module tb_instr_fetch_unit;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       Stall = 1'b0;
    logic       Branch_Taken = 1'b0;
    logic [7:0] Branch_Target = '0;
    logic       prog_we = 1'b0;
    logic [7:0] prog_addr = '0;
    logic [7:0] prog_data = '0;

    logic [7:0] instr1, npc1, pc1, instr2, npc2, pc2;
    logic       flush1, halted1, flush2, halted2;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    always #5 clk = ~clk;

    instr_fetch_unit #(.ADDR_W(8), .FLUSH_CYCLES(1), .RESET_PC(8'h00)) u_dut1 (
        .clk(clk), .reset(reset), .Stall(Stall), .Branch_Taken(Branch_Taken),
        .Branch_Target(Branch_Target), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .Instr(instr1), .NPC(npc1), .PC(pc1),
        .Flush(flush1), .Halted(halted1)
    );

    instr_fetch_unit #(.ADDR_W(8), .FLUSH_CYCLES(2), .RESET_PC(8'h00)) u_dut2 (
        .clk(clk), .reset(reset), .Stall(Stall), .Branch_Taken(Branch_Taken),
        .Branch_Target(Branch_Target), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_data(prog_data), .Instr(instr2), .NPC(npc2), .PC(pc2),
        .Flush(flush2), .Halted(halted2)
    );

    task automatic check(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [7:0] prog_tbl [4];
        prog_tbl[0] = 8'h11;
        prog_tbl[1] = 8'h22;
        prog_tbl[2] = 8'h33;
        prog_tbl[3] = 8'h44;

        // Reset state, including a branch request that must not flush during reset
        #2;
        check("rst_pc1", pc1, 8'h00);
        check("rst_pc2", pc2, 8'h00);
        Branch_Taken = 1'b1;
        #1;
        check("rst_flush1", flush1, 1'b0);
        check("rst_flush2", flush2, 1'b0);
        Branch_Taken = 1'b0;

        for (int i = 0; i < 256; i++) begin
            prog_we   = 1'b1;
            prog_addr = 8'(i);
            prog_data = (i < 4) ? prog_tbl[i] : 8'h00;
            step();
        end
        prog_we = 1'b0;
        check("rst_hold_pc", pc1, 8'h00);

        // Free run
        reset = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            check("run_pc", pc1, 8'(i));
            check("run_instr", instr1, prog_tbl[i]);
            check("run_npc", npc1, 8'(i + 1));
            check("run_flush", {flush1, flush2}, 2'b00);
            if (i < 2) step();
        end

        // Stall at PC=2
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_pc", pc1, 8'h02);
            check("stall_instr", instr1, 8'h33);
        end
        Stall = 1'b0;
        step();
        check("stall_rel_pc", pc1, 8'h03);
        check("stall_rel_instr", instr1, 8'h44);
        check("stall_rel_npc", npc1, 8'h04);
        step();
        step();
        check("pre_br_pc", pc2, 8'h05);

        // Branch with concurrent Stall
        Branch_Taken  = 1'b1;
        Branch_Target = 8'h40;
        Stall         = 1'b1;
        #1;
        check("br1_flush1", flush1, 1'b1);
        check("br1_flush2", flush2, 1'b1);
        step();
        Branch_Taken = 1'b0;
        Stall        = 1'b0;
        #1;
        check("br1_pc1", pc1, 8'h40);
        check("br1_pc2", pc2, 8'h40);
        check("br1_after_flush1", flush1, 1'b0);
        check("br1_after_flush2", flush2, 1'b1);
        step();
        check("br1_pc_next", pc1, 8'h41);
        check("br1_end_flush2", flush2, 1'b0);

        // Back-to-back redirects reload the countdown
        Branch_Taken  = 1'b1;
        Branch_Target = 8'h80;
        #1;
        check("br2_flush1", flush1, 1'b1);
        step();
        check("br2_pc", pc2, 8'h80);
        Branch_Target = 8'h90;
        #1;
        check("br3_flush2", flush2, 1'b1);
        step();
        Branch_Taken = 1'b0;
        #1;
        check("br3_pc1", pc1, 8'h90);
        check("br3_pc2", pc2, 8'h90);
        check("br3_flush1", flush1, 1'b0);
        check("br3_flush2_tail", flush2, 1'b1);
        step();
        check("br3_pc_next", pc2, 8'h91);
        check("br3_end_flush2", flush2, 1'b0);

        // Write to the address being fetched: old data now, new data next cycle
        Stall     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 8'h91;
        prog_data = 8'hA5;
        #1;
        check("wr_old_instr", instr1, 8'h00);
        step();
        prog_we = 1'b0;
        Stall   = 1'b0;
        check("wr_new_instr", instr1, 8'hA5);
        check("wr_new_instr2", instr2, 8'hA5);

        // Wrap from 8'hFF
        Branch_Taken  = 1'b1;
        Branch_Target = 8'hFE;
        step();
        Branch_Taken = 1'b0;
        check("wrap_fe", pc1, 8'hFE);
        step();
        check("wrap_ff", pc1, 8'hFF);
        check("wrap_npc", npc1, 8'h00);
        step();
        check("wrap_pc0", pc1, 8'h00);
        check("wrap_instr", instr1, 8'h11);

        // Async reset in the middle of a flush countdown
        Branch_Taken  = 1'b1;
        Branch_Target = 8'h20;
        step();
        Branch_Taken = 1'b0;
        #1;
        check("ar_pre_pc", pc2, 8'h20);
        check("ar_pre_flush2", flush2, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check("ar_pc1", pc1, 8'h00);
        check("ar_pc2", pc2, 8'h00);
        check("ar_flush2", flush2, 1'b0);
        check("ar_flush1", flush1, 1'b0);
        reset = 1'b0;
        step();
        check("ar_run_pc", pc2, 8'h01);
        check("ar_run_flush2", flush2, 1'b0);

`ifdef IFU_HALT_DETECT_EN
        Stall     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 8'h07;
        prog_data = 8'hFF;
        step();
        prog_we = 1'b0;
        Stall   = 1'b0;
        for (int i = 0; i < 6; i++) step();
        check("h_reach_pc", pc1, 8'h07);
        check("h_reach_instr", instr1, 8'hFF);
        check("h_reach_halted", halted1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step();
            check("h_pc1", pc1, 8'h07);
            check("h_halted1", halted1, 1'b1);
            check("h_pc2", pc2, 8'h07);
            check("h_halted2", halted2, 1'b1);
        end
        Branch_Taken  = 1'b1;
        Branch_Target = 8'h00;
        step();
        Branch_Taken = 1'b0;
        check("h_clr_halted1", halted1, 1'b0);
        check("h_clr_halted2", halted2, 1'b0);
        check("h_clr_pc", pc1, 8'h00);
        step();
        check("h_resume_pc", pc1, 8'h01);

        // Redirect onto the HALT: only the instance still flushing ignores it
        Branch_Taken  = 1'b1;
        Branch_Target = 8'h07;
        step();
        Branch_Taken = 1'b0;
        #1;
        check("hf_flush2", flush2, 1'b1);
        check("hf_flush1", flush1, 1'b0);
        step();
        check("hf_pc1", pc1, 8'h07);
        check("hf_halted1", halted1, 1'b1);
        check("hf_pc2", pc2, 8'h08);
        check("hf_halted2", halted2, 1'b0);
`else
        Stall     = 1'b1;
        prog_we   = 1'b1;
        prog_addr = 8'h01;
        prog_data = 8'hFF;
        step();
        prog_we = 1'b0;
        step();
        check("nh_instr", instr1, 8'hFF);
        Stall = 1'b0;
        step();
        check("nh_pc", pc1, 8'h02);
        check("nh_halted1", halted1, 1'b0);
        check("nh_halted2", halted2, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
